// File: rtl/fwrisc_exec_mds_stim_seq_if.sv
// fwrisc_exec_mds_stim_seq_if: push-side and decode-side signals of the MDS stimulus sequencer
interface fwrisc_exec_mds_stim_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  push_valid;
  logic                  push_ready;
  logic [3:0]            push_op;
  logic [DATA_WIDTH-1:0] push_op_a;
  logic [DATA_WIDTH-1:0] push_op_b;
  logic [4:0]            push_rd;
  logic [3:0]            gap;
  logic                  decode_valid;
  logic                  instr_complete;
  logic                  instr_c;
  logic [4:0]            op_type;
  logic [5:0]            op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] op_c;
  logic [5:0]            rd;
  logic [31:0]           mtvec;
  logic                  busy;
  logic                  timeout;
  logic [15:0]           issued_cnt;
  logic [15:0]           done_cnt;
  modport master (
    output push_valid, push_op, push_op_a, push_op_b, push_rd, gap, instr_complete,
    input  push_ready, decode_valid, instr_c, op_type, op, op_a, op_b, op_c, rd, mtvec,
           busy, timeout, issued_cnt, done_cnt
  );
  modport slave (
    input  push_valid, push_op, push_op_a, push_op_b, push_rd, gap, instr_complete,
    output push_ready, decode_valid, instr_c, op_type, op, op_a, op_b, op_c, rd, mtvec,
           busy, timeout, issued_cnt, done_cnt
  );
endinterface

// File: rtl/fwrisc_exec_mds_stim_seq.sv
// fwrisc_exec_mds_stim_seq: queued, back-pressured MDS op issuer with gaps, watchdog and counters
module fwrisc_exec_mds_stim_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int OP_NUM = 11,
  parameter int TIMEOUT = 64,
  parameter logic [4:0] OP_TYPE_MDS = 5'd7
) (
  input logic clock,
  input logic reset,
  fwrisc_exec_mds_stim_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] SH_MASK = DATA_WIDTH'((64'd1 << SW) - 64'd1);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state;
  logic [5:0] op_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_q [DEPTH];
  logic [DATA_WIDTH-1:0] b_q [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [WW-1:0] wd;
  logic [3:0] gap_cnt;
  logic dv_r, timeout_r;
  logic [5:0] op_r;
  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [4:0] rd_r;
  logic [15:0] issued_cnt, done_cnt;
  logic push, pop;
  logic [5:0] op_n;
  logic [DATA_WIDTH-1:0] b_n;
  assign bus.push_ready = count < (AW+1)'(DEPTH);
  assign push = bus.push_valid && bus.push_ready;
  assign pop = state == IDLE && count != '0;
  // Normalise on the way in so the FIFO already holds legal ops and masked shift amounts
  assign op_n = 6'(32'(bus.push_op) % OP_NUM);
  assign b_n = op_n < 6'd3 ? bus.push_op_b & SH_MASK : bus.push_op_b;
  assign bus.decode_valid = dv_r && !bus.instr_complete;
  assign bus.busy = state != IDLE || count != '0;
  assign bus.instr_c = 1'b0;
  assign bus.op_type = OP_TYPE_MDS;
  assign bus.op = op_r;
  assign bus.op_a = a_r;
  assign bus.op_b = b_r;
  assign bus.op_c = '0;
  assign bus.rd = {1'b0, rd_r};
  assign bus.mtvec = '0;
  assign bus.timeout = timeout_r;
  assign bus.issued_cnt = issued_cnt;
  assign bus.done_cnt = done_cnt;
  always_ff @(posedge clock) begin
    if (push) begin
      op_q[wr_ptr] <= op_n;
      a_q[wr_ptr] <= bus.push_op_a;
      b_q[wr_ptr] <= b_n;
      rd_q[wr_ptr] <= bus.push_rd;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wd <= '0;
      gap_cnt <= '0;
      dv_r <= 1'b0;
      timeout_r <= 1'b0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      rd_r <= '0;
      issued_cnt <= '0;
      done_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          op_r <= op_q[rd_ptr];
          a_r <= a_q[rd_ptr];
          b_r <= b_q[rd_ptr];
          rd_r <= rd_q[rd_ptr];
          dv_r <= 1'b1;
          issued_cnt <= issued_cnt + 16'(issued_cnt != 16'hFFFF);
          wd <= '0;
          state <= BUSY;
        end
        BUSY: begin
          wd <= wd + WW'(1);
          if (bus.instr_complete) begin
            dv_r <= 1'b0;
            done_cnt <= done_cnt + 16'(done_cnt != 16'hFFFF);
            gap_cnt <= bus.gap;
            state <= bus.gap != 4'd0 ? GAP : IDLE;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            timeout_r <= 1'b1;
            dv_r <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          state <= gap_cnt == 4'd1 ? IDLE : GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fwrisc_exec_mds_stim_seq.sv
// tb_fwrisc_exec_mds_stim_seq: random push/complete traffic checked against a queue-and-timestamp model
module tb_fwrisc_exec_mds_stim_seq;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int OP_NUM = 11;
  localparam int TIMEOUT = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  fwrisc_exec_mds_stim_seq_if #(.DATA_WIDTH(DW)) bus ();
  fwrisc_exec_mds_stim_seq #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .OP_NUM(OP_NUM), .TIMEOUT(TIMEOUT), .OP_TYPE_MDS(5'd7)
  ) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct packed {
    logic [5:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] rd;
  } desc_t;
  desc_t q[$];
  desc_t cur;
  int t, issue_t, next_pop, m_issued, m_done;
  bit inflight, m_timeout;
  int n_cmp, n_err;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    cur = '0;
    inflight = 0;
    m_timeout = 0;
    m_issued = 0;
    m_done = 0;
    next_pop = 0;
  endtask
  function automatic desc_t norm(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd);
    desc_t d;
    int o;
    o = int'(op) % OP_NUM;
    d.op = 6'(o);
    d.a = a;
    d.b = o < 3 ? b % DW : b;
    d.rd = rd;
    return d;
  endfunction
  // One clock edge of the reference: completion, watchdog or issue, then the push
  task automatic model_step();
    int pre_size;
    pre_size = q.size();
    if (inflight && bus.instr_complete) begin
      inflight = 0;
      m_done = m_done < 65535 ? m_done + 1 : m_done;
      next_pop = t + int'(bus.gap) + 1;
    end else if (inflight && t - issue_t == TIMEOUT) begin
      inflight = 0;
      m_timeout = 1;
      next_pop = t + 1;
    end else if (!inflight && t >= next_pop && pre_size > 0) begin
      cur = q.pop_front();
      inflight = 1;
      issue_t = t;
      m_issued = m_issued < 65535 ? m_issued + 1 : m_issued;
    end
    if (bus.push_valid && pre_size < DEPTH)
      q.push_back(norm(bus.push_op, bus.push_op_a, bus.push_op_b, bus.push_rd));
  endtask
  task automatic check_all();
    check("push_ready", 64'(bus.push_ready), 64'(q.size() < DEPTH));
    check("decode_valid", 64'(bus.decode_valid), 64'(inflight && !bus.instr_complete));
    check("op", 64'(bus.op), 64'(cur.op));
    check("op_a", 64'(bus.op_a), 64'(cur.a));
    check("op_b", 64'(bus.op_b), 64'(cur.b));
    check("rd", 64'(bus.rd), 64'({1'b0, cur.rd}));
    check("issued_cnt", 64'(bus.issued_cnt), 64'(m_issued));
    check("done_cnt", 64'(bus.done_cnt), 64'(m_done));
    check("timeout", 64'(bus.timeout), 64'(m_timeout));
    check("busy", 64'(bus.busy), 64'(inflight || t < next_pop - 1 || q.size() != 0));
    check("consts", {bus.op_type, bus.instr_c, bus.op_c, bus.mtvec[25:0]}, 64'(5'd7 << 59));
  endtask
  task automatic drive_random(input int cprob, input int pprob);
    bus.push_valid = $urandom_range(0, 99) < pprob;
    bus.push_op = 4'($urandom);
    bus.push_op_a = $urandom;
    bus.push_op_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 70));
    bus.push_rd = 5'($urandom);
    bus.gap = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 3));
    bus.instr_complete = $urandom_range(0, 99) < cprob;
  endtask
  task automatic run(input int cycles, input int cprob, input int pprob);
    for (int i = 0; i < cycles; i++) begin
      drive_random(cprob, pprob);
      #2;
      check_all();
      @(posedge clock);
      t++;
      model_step();
      #1;
    end
  endtask
  initial begin
    bus.push_valid = 1'b0;
    bus.push_op = '0;
    bus.push_op_a = '0;
    bus.push_op_b = '0;
    bus.push_rd = '0;
    bus.gap = '0;
    bus.instr_complete = 1'b0;
    t = 0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;
    run(1500, 40, 50);
    run(300, 3, 60);
    run(20, 0, 100);
    check("reach_busy", 64'(inflight), 64'd1);
    reset = 1'b1;
    bus.push_valid = 1'b0;
    bus.instr_complete = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;
    run(600, 30, 50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
